// File: rtl/chest_pkg.sv
// Shared constants, FSM encoding and pilot-arithmetic helpers for the
// NRS time-domain channel interpolator.
package chest_pkg;

  localparam int unsigned WIDTH_R_I  = 16;
  localparam int unsigned RECIP_FRAC = 12;
  localparam int unsigned SYM_A      = 5;
  localparam int unsigned SYM_B      = 12;
  localparam int unsigned NUM_SYM    = 14;
  localparam int unsigned RECIP      =
    ((2 ** RECIP_FRAC) + (SYM_B - SYM_A) / 2) / (SYM_B - SYM_A);

  localparam int unsigned EST_W  = WIDTH_R_I + 1;
  localparam int unsigned SUM_W  = WIDTH_R_I + 2;
  localparam int unsigned STEP_W = SUM_W + RECIP_FRAC + 1;
  localparam int unsigned ACC_W  = WIDTH_R_I + RECIP_FRAC + 8;
  localparam int unsigned SYM_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [EST_W-1:0] r;
    logic signed [EST_W-1:0] i;
  } est_t;

  // Frequency average of one pilot pair; the arithmetic shift floors.
  function automatic logic signed [SUM_W-1:0] pair_avg(
    input logic signed [EST_W-1:0] a,
    input logic signed [EST_W-1:0] b
  );
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return s >>> 1;
  endfunction

  // Per-symbol increment in RECIP_FRAC fixed point.
  function automatic logic signed [STEP_W-1:0] calc_step(
    input logic signed [SUM_W-1:0] h_a,
    input logic signed [SUM_W-1:0] h_b
  );
    logic signed [SUM_W-1:0]  delta;
    logic signed [STEP_W-1:0] recip_s;
    delta   = h_b - h_a;
    recip_s = STEP_W'(RECIP);
    return STEP_W'(delta) * recip_s;
  endfunction

  // Extrapolate back from SYM_A to symbol 0.
  function automatic logic signed [ACC_W-1:0] calc_acc0(
    input logic signed [SUM_W-1:0]  h_a,
    input logic signed [STEP_W-1:0] step
  );
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sym_a_s;
    base    = ACC_W'(h_a) <<< RECIP_FRAC;
    sym_a_s = ACC_W'(SYM_A);
    return base - sym_a_s * ACC_W'(step);
  endfunction

endpackage

// File: rtl/chest_sat.sv
// Generic signed saturating narrower: clips an IN_W value into OUT_W bits.
module chest_sat #(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned OUT_W = 17
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout_c
);

  localparam int unsigned EXT_W = IN_W - OUT_W + 1;

  logic [EXT_W-1:0] ext_c;

  // In range when every bit above the output sign bit matches it.
  always_comb begin
    ext_c = din[IN_W-1 -: EXT_W];
    if ((&ext_c) || !(|ext_c)) begin
      dout_c = din[OUT_W-1:0];
    end else if (din[IN_W-1]) begin
      dout_c = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      dout_c = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/chest_time_interp.sv
// Reads four NRS LS estimates, averages each pilot pair and streams a linearly
// inter/extrapolated channel estimate per OFDM symbol over valid/ready.
module chest_time_interp
  import chest_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [1:0]              est_rd_addr,
  input  logic signed [EST_W-1:0] est_r_in,
  input  logic signed [EST_W-1:0] est_i_in,
  output logic signed [EST_W-1:0] h_r,
  output logic signed [EST_W-1:0] h_i,
  output logic [SYM_W-1:0]        sym_idx,
  output logic                    h_valid,
  input  logic                    h_ready,
  output logic                    busy,
  output logic                    done
);

  state_t                   state;
  logic [1:0]               rd_cnt;
  est_t                     est_q [4];
  logic signed [STEP_W-1:0] step_r;
  logic signed [STEP_W-1:0] step_i;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  acc_i;

  logic signed [SUM_W-1:0]  h_a_r_c;
  logic signed [SUM_W-1:0]  h_b_r_c;
  logic signed [SUM_W-1:0]  h_a_i_c;
  logic signed [SUM_W-1:0]  h_b_i_c;
  logic signed [STEP_W-1:0] step_r_c;
  logic signed [STEP_W-1:0] step_i_c;
  logic signed [ACC_W-1:0]  acc0_r_c;
  logic signed [ACC_W-1:0]  acc0_i_c;
  logic                     accept_c;
  logic                     last_c;
  logic signed [ACC_W-1:0]  acc_nxt_r_c;
  logic signed [ACC_W-1:0]  acc_nxt_i_c;
  logic signed [ACC_W-1:0]  shift_r_c;
  logic signed [ACC_W-1:0]  shift_i_c;
  logic signed [EST_W-1:0]  sat_r_c;
  logic signed [EST_W-1:0]  sat_i_c;

  assign est_rd_addr = rd_cnt;

  // Pilot averaging and interpolation seed, consumed in CALC.
  always_comb begin
    h_a_r_c  = pair_avg(est_q[0].r, est_q[1].r);
    h_b_r_c  = pair_avg(est_q[2].r, est_q[3].r);
    h_a_i_c  = pair_avg(est_q[0].i, est_q[1].i);
    h_b_i_c  = pair_avg(est_q[2].i, est_q[3].i);
    step_r_c = calc_step(h_a_r_c, h_b_r_c);
    step_i_c = calc_step(h_a_i_c, h_b_i_c);
    acc0_r_c = calc_acc0(h_a_r_c, step_r_c);
    acc0_i_c = calc_acc0(h_a_i_c, step_i_c);
  end

  // Output register always loads the estimate of the symbol shown next cycle.
  always_comb begin
    accept_c    = h_valid && h_ready;
    last_c      = (sym_idx == SYM_W'(NUM_SYM - 1));
    acc_nxt_r_c = acc_r;
    acc_nxt_i_c = acc_i;
    if (accept_c) begin
      acc_nxt_r_c = acc_r + ACC_W'(step_r);
      acc_nxt_i_c = acc_i + ACC_W'(step_i);
    end
    shift_r_c = acc_nxt_r_c >>> RECIP_FRAC;
    shift_i_c = acc_nxt_i_c >>> RECIP_FRAC;
  end

  chest_sat #(.IN_W(ACC_W), .OUT_W(EST_W)) u_sat_r (
    .din    (shift_r_c),
    .dout_c (sat_r_c)
  );

  chest_sat #(.IN_W(ACC_W), .OUT_W(EST_W)) u_sat_i (
    .din    (shift_i_c),
    .dout_c (sat_i_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      step_r  <= '0;
      step_i  <= '0;
      acc_r   <= '0;
      acc_i   <= '0;
      h_r     <= '0;
      h_i     <= '0;
      sym_idx <= '0;
      h_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        est_q[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RD;
            rd_cnt <= '0;
            busy   <= 1'b1;
          end
        end
        RD: begin
          est_q[rd_cnt] <= '{r: est_r_in, i: est_i_in};
          rd_cnt        <= rd_cnt + 2'd1;
          if (rd_cnt == 2'd3) begin
            state <= CALC;
          end
        end
        CALC: begin
          step_r  <= step_r_c;
          step_i  <= step_i_c;
          acc_r   <= acc0_r_c;
          acc_i   <= acc0_i_c;
          sym_idx <= '0;
          state   <= OUT;
        end
        OUT: begin
          if (!h_valid) begin
            h_valid <= 1'b1;
            h_r     <= sat_r_c;
            h_i     <= sat_i_c;
          end else if (accept_c) begin
            if (last_c) begin
              state   <= IDLE;
              h_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              acc_r   <= acc_nxt_r_c;
              acc_i   <= acc_nxt_i_c;
              sym_idx <= sym_idx + SYM_W'(1);
              h_r     <= sat_r_c;
              h_i     <= sat_i_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
